memory_bfm_timed: RTL

//  Parametrised behavioural memory for the L1 cache UVM bench; sits on the cache's generic_bus_if in place of the real bus.

---
 rtl/memory_bfm_timed.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/memory_bfm_timed.sv
// Behavioural word memory for the cache bus: fill pattern for unwritten words, byte-enabled writes, op counters, protocol pulse.
// Completes LATENCY+1 cycles after acceptance (busy low for one cycle); requester holds ren/wen until then, one IDLE cycle between ops.
module memory_bfm_timed #(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter int          FILL_MODE = 0,
    parameter logic [15:0] TAG       = 16'hdada
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic                ren,
    input  logic                wen,
    output logic [DATA_W-1:0]   rdata,
    output logic                busy,
    output logic [15:0]         rd_count,
    output logic [15:0]         wr_count,
    output logic                protocol_err
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic                is_wr_q, is_wr_d;
    logic                err_seen_q, err_seen_d;
    logic                protocol_err_q, protocol_err_d;
    logic [15:0]         rd_count_q, rd_count_d;
    logic [15:0]         wr_count_q, wr_count_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DEPTH-1:0]    written_q, written_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [DATA_W-1:0]   merged;

    logic [IDX_W-1:0]    idx;
    logic [31:0]         fill32;
    logic [DATA_W-1:0]   fill_val;
    logic [DATA_W-1:0]   cur_word;
    logic                viol;

    assign idx      = addr_q[IDX_W+OFF_W-1:OFF_W];
    assign fill32   = {TAG, addr_q[15:0]};
    assign fill_val = (FILL_MODE != 0) ? '0 : DATA_W'(fill32);
    assign cur_word = written_q[idx] ? mem_q[idx] : fill_val;

    // Any deviation of the live request from what was latched at acceptance.
    assign viol = (addr != addr_q) ||
                  (is_wr_q ? (!wen || (wdata != wdata_q) || (byte_en != be_q))
                           : (!ren || wen));

    always_comb begin
        merged = cur_word;
        for (int b = 0; b < BE_W; b++) begin
            if (be_q[b]) merged[b*8 +: 8] = wdata_q[b*8 +: 8];
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        be_d           = be_q;
        is_wr_d        = is_wr_q;
        err_seen_d     = err_seen_q;
        protocol_err_d = 1'b0;
        rd_count_d     = rd_count_q;
        wr_count_d     = wr_count_q;
        rdata_d        = rdata_q;
        written_d      = written_q;
        mem_we         = 1'b0;
        case (state_q)
            IDLE: begin
                if (ren || wen) begin
                    addr_d         = addr;
                    wdata_d        = wdata;
                    be_d           = byte_en;
                    is_wr_d        = wen;
                    cnt_d          = 8'(LATENCY);
                    protocol_err_d = ren && wen;
                    err_seen_d     = ren && wen;
                    state_d        = (LATENCY > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) state_d = RESP;
                if (viol && !err_seen_q) begin
                    protocol_err_d = 1'b1;
                    err_seen_d     = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (is_wr_q) begin
                    if (wr_count_q != 16'hffff) wr_count_d = wr_count_q + 16'd1;
                    // An all-zero byte enable leaves the word, and its written bit, untouched.
                    if (be_q != '0) begin
                        mem_we         = 1'b1;
                        written_d[idx] = 1'b1;
                    end
                end else begin
                    if (rd_count_q != 16'hffff) rd_count_d = rd_count_q + 16'd1;
                    rdata_d = cur_word;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            be_q           <= '0;
            is_wr_q        <= 1'b0;
            err_seen_q     <= 1'b0;
            protocol_err_q <= 1'b0;
            rd_count_q     <= '0;
            wr_count_q     <= '0;
            rdata_q        <= '0;
            written_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            be_q           <= be_d;
            is_wr_q        <= is_wr_d;
            err_seen_q     <= err_seen_d;
            protocol_err_q <= protocol_err_d;
            rd_count_q     <= rd_count_d;
            wr_count_q     <= wr_count_d;
            rdata_q        <= rdata_d;
            written_q      <= written_d;
        end
    end

    // Storage contents need no reset; the written map decides what is visible.
    always_ff @(posedge CLK) begin
        if (mem_we) mem_q[idx] <= merged;
    end

    assign busy         = (state_q != RESP);
    assign rdata        = (state_q == RESP && !is_wr_q) ? cur_word : rdata_q;
    assign rd_count     = rd_count_q;
    assign wr_count     = wr_count_q;
    assign protocol_err = protocol_err_q;

endmodule
